// File: rtl/decoder_pkg.sv
// Shared state encodings and mode constants for the sequenced N-to-2**N decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_n_seq_if.sv
// Control inputs and registered channel-select outputs of decoder_n_seq.
interface decoder_n_seq_if #(
    parameter int N = 2
);
    logic              en;
    logic              mode;
    logic [N-1:0]      sel;
    logic [2**N-1:0]   mask;
    logic [2**N-1:0]   y;
    logic [N-1:0]      idx;
    logic              valid;
    logic              wrap;

    modport master (
        output en, mode, sel, mask,
        input  y, idx, valid, wrap
    );

    modport slave (
        input  en, mode, sel, mask,
        output y, idx, valid, wrap
    );
endinterface

// File: rtl/decoder_n_df.sv
// Combinational N-to-2**N one-hot decoder with enable; all-zero when disabled.
module decoder_n_df #(
    parameter int N = 2
) (
    input  logic              en,
    input  logic [N-1:0]      a,
    output logic [2**N-1:0]   y
);

    // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_n_seq.sv
// Sequenced channel decoder: direct decode of sel, or timed scan over the set bits of mask.
module decoder_n_seq
    import decoder_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    decoder_n_seq_if.slave   bus
);

    localparam int              W    = 2**N;
    localparam int              CW   = $clog2(DWELL + 1);
    localparam logic [CW-1:0]   LAST = CW'(DWELL - 1);

    // Next set bit of m strictly above cur, wrapping around; cur = all-ones yields the lowest set bit.
    function automatic logic [N-1:0] next_channel(input logic [W-1:0] m, input logic [N-1:0] cur);
        logic [N-1:0] j;
        logic         found;
        next_channel = cur;
        found        = 1'b0;
        for (int k = 1; k <= W; k++) begin
            j = cur + N'(k);
            if (!found && m[j]) begin
                next_channel = j;
                found        = 1'b1;
            end
        end
    endfunction

    state_t          state_q, state_d;
    logic [N-1:0]    idx_q, idx_d, nxt;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    y_q, y_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if (bus.en) begin
            if (bus.mode == MODE_DIRECT) begin
                state_d = ST_DIRECT;
            end else if (|bus.mask) begin
                state_d = ST_SCAN;
            end
        end
    end

    always_comb begin
        idx_d   = idx_q;
        cnt_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        nxt     = next_channel(bus.mask, idx_q);
        unique case (state_d)
            ST_DIRECT: begin
                idx_d   = bus.sel;
                valid_d = 1'b1;
            end
            ST_SCAN: begin
                valid_d = 1'b1;
                if (state_q != ST_SCAN) begin
                    idx_d = next_channel(bus.mask, '1);
                end else if (!bus.mask[idx_q] || cnt_q == LAST) begin
                    // A dropped mask bit abandons the current channel immediately.
                    idx_d  = nxt;
                    wrap_d = (nxt <= idx_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    decoder_n_df #(
        .N (N)
    ) u_dec (
        .en (valid_d),
        .a  (idx_d),
        .y  (y_d)
    );

    assign bus.y     = y_q;
    assign bus.idx   = idx_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Scoreboard bench for decoder_n_seq with N=2, DWELL=2.
module tb_decoder_n_seq;

    typedef struct {
        logic [3:0] y;
        logic [1:0] idx;
        logic       valid;
        logic       wrap;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   step_no;
    exp_t sb[$];

    decoder_n_seq_if #(.N(2)) bus ();

    decoder_n_seq #(
        .N     (2),
        .DWELL (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left in the low clock phase: drive, push expectation, compare after the edge.
    task automatic step(input logic e, input logic m, input logic [1:0] s, input logic [3:0] mk,
                        input logic [1:0] ei, input logic ev, input logic ew);
        exp_t ex;
        exp_t got;
        bus.en   = e;
        bus.mode = m;
        bus.sel  = s;
        bus.mask = mk;
        ex.idx   = ei;
        ex.valid = ev;
        ex.wrap  = ew;
        ex.y     = ev ? (4'b0001 << ei) : 4'b0000;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        step_no++;
        if (sb.size() == 0) begin
            check($sformatf("s%0d_sb_empty", step_no), 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check($sformatf("s%0d_y", step_no),     32'(bus.y),     32'(got.y));
            check($sformatf("s%0d_idx", step_no),   32'(bus.idx),   32'(got.idx));
            check($sformatf("s%0d_valid", step_no), 32'(bus.valid), 32'(got.valid));
            check($sformatf("s%0d_wrap", step_no),  32'(bus.wrap),  32'(got.wrap));
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_y"},     32'(bus.y),     32'd0);
        check({tag, "_idx"},   32'(bus.idx),   32'd0);
        check({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_wrap"},  32'(bus.wrap),  32'd0);
    endtask

    initial begin
        logic [1:0] scan4 [10];
        logic [1:0] s;
        n_vec    = 0;
        n_err    = 0;
        step_no  = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.mode = 1'b0;
        bus.sel  = '0;
        bus.mask = '0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Direct decode, sel stepping 0..3, then random sel with random (ignored) mask.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'(i), 4'h0, 2'(i), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            s = 2'($urandom_range(0, 3));
            step(1'b1, 1'b0, s, 4'($urandom_range(0, 15)), s, 1'b1, 1'b0);
        end

        // Full-mask scan: two cycles per channel, wrap on return to 0.
        scan4 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 2'd0, 4'b1111, scan4[i], 1'b1, i == 8);

        // Disable: outputs clear, idx holds.
        step(1'b0, 1'b1, 2'd0, 4'b1111, 2'd0, 1'b0, 1'b0);

        // Sparse mask 1010.
        step(1'b1, 1'b1, 2'd0, 4'b1010, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1010, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1010, 2'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1010, 2'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1010, 2'd1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 2'd0, 4'b1010, 2'd1, 1'b1, 1'b0);

        // Single bit 0100: idx1 leaves its mask, then channel 2 wraps onto itself every 2 cycles.
        step(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b1);
        step(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b1);
        step(1'b1, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 1'b0);

        // Through DIRECT to discard scan position, then clear mask bit 1 mid-dwell.
        step(1'b1, 1'b0, 2'd0, 4'b1111, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1101, 2'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1101, 2'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1101, 2'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1101, 2'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1101, 2'd0, 1'b1, 1'b1);

        // Empty mask in scan mode, then direct followed by disable.
        step(1'b1, 1'b1, 2'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd2, 4'b0000, 2'd2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 2'd2, 4'b0000, 2'd2, 1'b0, 1'b0);

        // Scan up to idx 2, then asynchronous reset mid-scan.
        step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b1111, 2'd2, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        bus.mask = 4'b0110;
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 2'd0, 4'b0110, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b0110, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b0110, 2'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b0110, 2'd2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'b0110, 2'd1, 1'b1, 1'b1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_n_seq.md
DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 Parameter N, default 2, select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter DWELL, default 4, cycles each channel is held in scan mode; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  block enable; 0 forces y to all-zero.
REQ-006 mode  input  1  0 = direct decode of sel, 1 = automatic channel scan.
REQ-007 sel  input  N  channel index for direct mode.
REQ-008 mask  input  2**N  per-channel scan enable; bit k=1 means channel k is visited in scan.
REQ-009 y  output  2**N  registered one-hot channel select, all-zero when not valid.
REQ-010 idx  output  N  registered index of the active channel.
REQ-011 valid  output  1  1 when y carries a one-hot value.
REQ-012 wrap  output  1  one-cycle pulse when the scan returns to a lower-or-equal channel.

Function
REQ-013 The block SHALL implement three states: IDLE, DIRECT, SCAN, evaluated every clock edge.
REQ-014 Next state SHALL be: en=0 -> IDLE; en=1,mode=0 -> DIRECT; en=1,mode=1,mask!=0 -> SCAN; en=1,mode=1,mask==0 -> IDLE.
REQ-015 IDLE: y=0, valid=0, wrap=0; idx holds its last value.
REQ-016 DIRECT: idx=sel, y=one-hot(sel), valid=1, wrap=0, one-cycle latency from sel to y; mask ignored.
REQ-017 SCAN entry from any other state: idx = lowest set bit of mask, dwell counter = 0, wrap=0.
REQ-018 SCAN: each channel SHALL stay selected exactly DWELL cycles, then idx advances to the next set mask bit above idx, wrapping to the lowest set bit.
REQ-019 wrap SHALL be 1 for exactly the first cycle of a channel whose index is <= the previous index; with a single set mask bit, wrap pulses every DWELL cycles and idx is unchanged.
REQ-020 If mask bit idx is cleared mid-dwell, the next edge SHALL advance to the next set bit (wrap rules apply) and restart the dwell count.
REQ-021 Mode change SCAN->DIRECT SHALL take effect on the next edge; scan position is discarded; a later return to SCAN restarts per REQ-017.
REQ-022 Whenever valid=1, y SHALL equal one-hot(idx); whenever valid=0, y SHALL be 0.
REQ-023 Dwell counter width SHALL be clog2(DWELL+1); no counter or index SHALL exceed its range.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, y=0, idx=0, valid=0, wrap=0, dwell counter=0.
REQ-025 After rst_n rises, the first state update SHALL occur on the next clk rising edge, per REQ-014.
REQ-026 Reset asserted mid-scan SHALL discard scan position; the next scan starts per REQ-017.

Structure
REQ-027 State encodings (IDLE, DIRECT, SCAN) and mode constants SHALL live in shared package decoder_pkg.
REQ-028 One-hot generation SHALL use sub-module decoder_n_df (combinational N-to-2**N decoder with enable), driving the y register input.
REQ-029 Next-channel search (next set mask bit above idx, with wrap) SHALL be a single combinational function inside decoder_n_seq.

Verification (N=2, DWELL=2)
REQ-030 Reset then en=1,mode=0, sel stepping 0..3 -> y=0001,0010,0100,1000 one cycle after each sel; valid=1.
REQ-031 en=1,mode=1,mask=1111 for 10 cycles -> idx 0,0,1,1,2,2,3,3,0,0; wrap=1 only on the first cycle at idx 0 after idx 3.
REQ-032 mask=1010 in scan -> idx 1,1,3,3,1,1; wrap on each return to 1; mask=0100 -> idx stays 2, wrap every 2 cycles.
REQ-033 Mid-dwell on idx=1 with mask=1111, clear mask to 1101 -> next edge idx=2, held 2 cycles.
REQ-034 mask=0000 in scan -> y=0, valid=0 next edge; en=0 at any time -> y=0 next edge.
REQ-035 rst_n=0 mid-scan at idx=2 -> y=0, idx=0, valid=0 immediately, without a clock edge; release -> scan restarts at the lowest set mask bit.
